// File: rtl/rotate_sram_arb_if.sv
// rtl/rotate_sram_arb_if.sv - requester and SRAM pin bundle for rotate_sram_arb
//
// Purpose: groups the three requester handshakes and the SRAM pin set.
// Ports (signals):
//   wr_*    pixel write stream: req/addr/data in, gnt out
//   rd_*    rotation read stream: req/addr in, gnt/dv/data out
//   host_*  host access: req/we/addr/wdata in, gnt/rdv/rdata out
//   sram_*  registered SRAM pins out, sram_din in
// Modports: master = requesters + SRAM device side, slave = arbiter side.
interface rotate_sram_arb_if #(
  parameter int ADDR_WIDTH = 21,
  parameter int DATA_WIDTH = 16
);
  logic                  wr_req;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_gnt;
  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_gnt;
  logic                  rd_dv;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  host_req;
  logic                  host_we;
  logic [ADDR_WIDTH-1:0] host_addr;
  logic [DATA_WIDTH-1:0] host_wdata;
  logic                  host_gnt;
  logic                  host_rdv;
  logic [DATA_WIDTH-1:0] host_rdata;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic                  sram_web;
  logic                  sram_oeb;
  logic [DATA_WIDTH-1:0] sram_dout;
  logic                  sram_doe;
  logic [DATA_WIDTH-1:0] sram_din;

  modport master (
    output wr_req, wr_addr, wr_data, rd_req, rd_addr,
           host_req, host_we, host_addr, host_wdata, sram_din,
    input  wr_gnt, rd_gnt, rd_dv, rd_data, host_gnt, host_rdv, host_rdata,
           sram_addr, sram_web, sram_oeb, sram_dout, sram_doe
  );

  modport slave (
    input  wr_req, wr_addr, wr_data, rd_req, rd_addr,
           host_req, host_we, host_addr, host_wdata, sram_din,
    output wr_gnt, rd_gnt, rd_dv, rd_data, host_gnt, host_rdv, host_rdata,
           sram_addr, sram_web, sram_oeb, sram_dout, sram_doe
  );
endinterface

// File: rtl/rotate_sram_arb.sv
// rtl/rotate_sram_arb.sv - single-port SRAM arbiter/sequencer for the rotation frame buffer
//
// Purpose: shares one async SRAM between the pixel write stream (highest
// priority), the rotation read stream and host access (lowest, with a
// starvation guard). Inserts a bus turnaround before a write that follows a
// read and returns read data RD_LATENCY cycles after the read command pins.
// Ports:
//   clk, resetb        clock, synchronous active-low reset
//   bus (slave)        requester handshakes and SRAM pins (rotate_sram_arb_if)
//   stat_clr, stat_*   only with ROTATE_SRAM_ARB_STATS_EN defined: grant and
//                      turnaround counters (32 bit, saturating) and their clear
// Optional feature macro: ROTATE_SRAM_ARB_STATS_EN
module rotate_sram_arb #(
  parameter int ADDR_WIDTH    = 21,
  parameter int DATA_WIDTH    = 16,
  parameter int RD_LATENCY    = 3,
  parameter int HOST_MAX_WAIT = 64
) (
  input logic               clk,
  input logic               resetb,
  rotate_sram_arb_if.slave  bus
`ifdef ROTATE_SRAM_ARB_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [31:0]       stat_wr_cnt,
  output logic [31:0]       stat_rd_cnt,
  output logic [31:0]       stat_host_cnt,
  output logic [31:0]       stat_turn_cnt
`endif
);

  localparam int WAIT_W = $clog2(HOST_MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(HOST_MAX_WAIT);

  // ST_RDBUS: the SRAM pins currently carry a read command, so a write
  // granted now would collide with the SRAM still driving the data bus.
  typedef enum logic {ST_ARB, ST_RDBUS} state_t;

  state_t            state_q, state_d;
  logic              gnt_wr, gnt_rd, gnt_host, turn;
  logic              host_force, host_sel;
  logic [WAIT_W-1:0] wait_q;
  logic [RD_LATENCY-1:0] tag_v, tag_host;
  logic              host_rd_issue, rd_issue;

  assign host_force = bus.host_req && (wait_q == WAIT_MAX);
  assign host_sel   = host_force || (bus.host_req && !bus.wr_req && !bus.rd_req);

  always_comb begin
    state_d  = ST_ARB;
    gnt_wr   = 1'b0;
    gnt_rd   = 1'b0;
    gnt_host = 1'b0;
    turn     = 1'b0;
    if (resetb) begin
      if (host_sel) begin
        if (bus.host_we && state_q == ST_RDBUS) begin
          turn = 1'b1;
        end else begin
          gnt_host = 1'b1;
          if (!bus.host_we) state_d = ST_RDBUS;
        end
      end else if (bus.wr_req) begin
        // Winning write held off one idle cycle; reads do not slip in ahead.
        if (state_q == ST_RDBUS) turn = 1'b1;
        else                     gnt_wr = 1'b1;
      end else if (bus.rd_req) begin
        gnt_rd  = 1'b1;
        state_d = ST_RDBUS;
      end
    end
  end

  assign bus.wr_gnt   = gnt_wr;
  assign bus.rd_gnt   = gnt_rd;
  assign bus.host_gnt = gnt_host;

  assign host_rd_issue = gnt_host && !bus.host_we;
  assign rd_issue      = gnt_rd || host_rd_issue;

  always_ff @(posedge clk) begin
    if (!resetb) begin
      state_q        <= ST_ARB;
      bus.sram_addr  <= '0;
      bus.sram_web   <= 1'b1;
      bus.sram_oeb   <= 1'b1;
      bus.sram_dout  <= '0;
      bus.sram_doe   <= 1'b0;
      wait_q         <= '0;
      tag_v          <= '0;
      tag_host       <= '0;
      bus.rd_dv      <= 1'b0;
      bus.rd_data    <= '0;
      bus.host_rdv   <= 1'b0;
      bus.host_rdata <= '0;
    end else begin
      state_q      <= state_d;
      bus.sram_web <= !(gnt_wr || (gnt_host && bus.host_we));
      bus.sram_oeb <= !rd_issue;
      if (gnt_wr) begin
        bus.sram_addr <= bus.wr_addr;
        bus.sram_dout <= bus.wr_data;
        bus.sram_doe  <= 1'b1;
      end else if (gnt_host) begin
        bus.sram_addr <= bus.host_addr;
        if (bus.host_we) bus.sram_dout <= bus.host_wdata;
        bus.sram_doe  <= bus.host_we;
      end else if (gnt_rd) begin
        bus.sram_addr <= bus.rd_addr;
        bus.sram_doe  <= 1'b0;
      end else if (turn) begin
        bus.sram_doe  <= 1'b0;
      end

      if (!bus.host_req || gnt_host) wait_q <= '0;
      else if (wait_q != WAIT_MAX)   wait_q <= wait_q + WAIT_W'(1);

      // Stage 0 lines up with the command cycle on the pins; the last stage
      // samples sram_din so the dv pulse lands RD_LATENCY cycles after it.
      tag_v    <= {tag_v[RD_LATENCY-2:0], rd_issue};
      tag_host <= {tag_host[RD_LATENCY-2:0], host_rd_issue};

      bus.rd_dv    <= tag_v[RD_LATENCY-1] && !tag_host[RD_LATENCY-1];
      bus.host_rdv <= tag_v[RD_LATENCY-1] && tag_host[RD_LATENCY-1];
      if (tag_v[RD_LATENCY-1]) begin
        if (tag_host[RD_LATENCY-1]) bus.host_rdata <= bus.sram_din;
        else                        bus.rd_data    <= bus.sram_din;
      end
    end
  end

`ifdef ROTATE_SRAM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!resetb || stat_clr) begin
      stat_wr_cnt   <= '0;
      stat_rd_cnt   <= '0;
      stat_host_cnt <= '0;
      stat_turn_cnt <= '0;
    end else begin
      if (gnt_wr && stat_wr_cnt != '1)     stat_wr_cnt   <= stat_wr_cnt + 32'd1;
      if (gnt_rd && stat_rd_cnt != '1)     stat_rd_cnt   <= stat_rd_cnt + 32'd1;
      if (gnt_host && stat_host_cnt != '1) stat_host_cnt <= stat_host_cnt + 32'd1;
      if (turn && stat_turn_cnt != '1)     stat_turn_cnt <= stat_turn_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rotate_sram_arb.sv
// tb/tb_rotate_sram_arb.sv - directed self-checking bench for rotate_sram_arb
module tb_rotate_sram_arb;
  logic clk;
  logic resetb;
  int   checks;
  int   failures;

  rotate_sram_arb_if #(.ADDR_WIDTH(21), .DATA_WIDTH(16)) bus ();

  rotate_sram_arb #(
    .ADDR_WIDTH(21), .DATA_WIDTH(16), .RD_LATENCY(3), .HOST_MAX_WAIT(64)
  ) dut (
    .clk(clk),
    .resetb(resetb),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: read data appears two cycles after the command pin cycle,
  // so the arbiter captures it in the third cycle after the command.
  logic [15:0] mem [logic [20:0]];
  logic        d1v;
  logic [20:0] d1a;

  always @(posedge clk) begin
    if (bus.sram_web == 1'b0) mem[bus.sram_addr] = bus.sram_dout;
    bus.sram_din <= (d1v && mem.exists(d1a)) ? mem[d1a] : 16'h0000;
    d1v <= !bus.sram_oeb;
    d1a <= bus.sram_addr;
  end

  logic [2:0] gnts;
  assign gnts = {bus.wr_gnt, bus.rd_gnt, bus.host_gnt};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    d1v = 1'b0;
    d1a = '0;
    bus.sram_din = '0;
    mem[21'h01234] = 16'hBEEF;
    mem[21'h00010] = 16'h1111;
    mem[21'h00020] = 16'h2222;
    mem[21'h00030] = 16'h3333;

    // 1. reset with every request asserted
    resetb = 1'b0;
    bus.wr_req = 1'b1; bus.wr_addr = 21'h000AA; bus.wr_data = 16'h5555;
    bus.rd_req = 1'b1; bus.rd_addr = 21'h01234;
    bus.host_req = 1'b1; bus.host_we = 1'b0;
    bus.host_addr = 21'h00077; bus.host_wdata = 16'hCAFE;
    for (int i = 0; i < 4; i++) begin
      step(); #1;
      check("rst_gnt", 32'(gnts), 32'd0);
      check("rst_web", 32'(bus.sram_web), 32'd1);
      check("rst_oeb", 32'(bus.sram_oeb), 32'd1);
      check("rst_doe", 32'(bus.sram_doe), 32'd0);
      check("rst_dv", 32'({bus.rd_dv, bus.host_rdv}), 32'd0);
    end
    step(); resetb = 1'b1; #1;
    check("rel_gnt", 32'(gnts), 32'b100);
    step(); bus.wr_req = 1'b0; bus.rd_req = 1'b0; bus.host_req = 1'b0; #1;
    check("rel_pins_web", 32'(bus.sram_web), 32'd0);
    check("rel_pins_doe", 32'(bus.sram_doe), 32'd1);
    check("rel_pins_addr", 32'(bus.sram_addr), 32'h000AA);
    check("rel_pins_dout", 32'(bus.sram_dout), 32'h5555);

    // 2. read latency
    step(); bus.rd_req = 1'b1; bus.rd_addr = 21'h01234; #1;
    check("lat_gnt", 32'(gnts), 32'b010);
    step(); bus.rd_req = 1'b0; #1;
    check("lat_oeb", 32'(bus.sram_oeb), 32'd0);
    check("lat_web", 32'(bus.sram_web), 32'd1);
    check("lat_doe", 32'(bus.sram_doe), 32'd0);
    check("lat_addr", 32'(bus.sram_addr), 32'h01234);
    step(); #1; check("lat_dv_c1", 32'(bus.rd_dv), 32'd0);
    step(); #1; check("lat_dv_c2", 32'(bus.rd_dv), 32'd0);
    step(); #1;
    check("lat_dv_c3", 32'(bus.rd_dv), 32'd1);
    check("lat_data", 32'(bus.rd_data), 32'hBEEF);
    step(); #1; check("lat_dv_c4", 32'(bus.rd_dv), 32'd0);

    // 3. read then write: turnaround
    step(); bus.rd_req = 1'b1; bus.rd_addr = 21'h00040; #1;
    check("turn_rd_gnt", 32'(gnts), 32'b010);
    step(); bus.rd_req = 1'b0; bus.wr_req = 1'b1; bus.wr_addr = 21'h00041; bus.wr_data = 16'hA5A5; #1;
    check("turn_no_gnt", 32'(gnts), 32'd0);
    check("turn_pin_rd", 32'({bus.sram_oeb, bus.sram_web}), 32'b01);
    step(); #1;
    check("turn_wr_gnt", 32'(gnts), 32'b100);
    check("turn_pin_idle", 32'({bus.sram_oeb, bus.sram_web, bus.sram_doe}), 32'b110);
    step(); bus.wr_req = 1'b0; #1;
    check("turn_pin_wr", 32'({bus.sram_oeb, bus.sram_web, bus.sram_doe}), 32'b101);
    check("turn_pin_addr", 32'(bus.sram_addr), 32'h00041);

    // 4. fixed priority wr > rd > host
    step(); bus.wr_req = 1'b1; bus.rd_req = 1'b1; bus.host_req = 1'b1; bus.host_we = 1'b0; #1;
    check("pri_wr0", 32'(gnts), 32'b100);
    step(); #1; check("pri_wr1", 32'(gnts), 32'b100);
    step(); bus.wr_req = 1'b0; #1; check("pri_rd", 32'(gnts), 32'b010);
    step(); bus.rd_req = 1'b0; #1; check("pri_host", 32'(gnts), 32'b001);
    step(); bus.host_req = 1'b0; #1; check("pri_none", 32'(gnts), 32'd0);
    repeat (5) step();

    // 5. host starvation guard
    step(); bus.wr_req = 1'b1; bus.wr_addr = 21'h00050; bus.wr_data = 16'h0F0F;
    bus.host_req = 1'b1; bus.host_we = 1'b1; #1;
    check("stv_wr_first", 32'(gnts), 32'b100);
    for (int k = 1; k < 64; k++) begin
      step(); #1;
      check("stv_wr_hold", 32'(gnts), 32'b100);
    end
    step(); #1; check("stv_host", 32'(gnts), 32'b001);
    step(); bus.host_req = 1'b0; #1;
    check("stv_wr_resume", 32'(gnts), 32'b100);
    check("stv_pin_web", 32'(bus.sram_web), 32'd0);
    check("stv_pin_addr", 32'(bus.sram_addr), 32'h00077);
    check("stv_pin_dout", 32'(bus.sram_dout), 32'hCAFE);
    step(); bus.wr_req = 1'b0; #1;
    check("stv_pin_wr_addr", 32'(bus.sram_addr), 32'h00050);

    // 6. mixed tags back to back
    step(); bus.rd_req = 1'b1; bus.rd_addr = 21'h00010; #1;
    check("mix_g0", 32'(gnts), 32'b010);
    step(); bus.rd_req = 1'b0; bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 21'h00020; #1;
    check("mix_g1", 32'(gnts), 32'b001);
    step(); bus.host_req = 1'b0; bus.rd_req = 1'b1; bus.rd_addr = 21'h00030; #1;
    check("mix_g2", 32'(gnts), 32'b010);
    step(); bus.rd_req = 1'b0; #1;
    check("mix_dv_m3", 32'({bus.rd_dv, bus.host_rdv}), 32'b00);
    step(); #1;
    check("mix_dv_m4", 32'({bus.rd_dv, bus.host_rdv}), 32'b10);
    check("mix_data_m4", 32'(bus.rd_data), 32'h1111);
    step(); #1;
    check("mix_dv_m5", 32'({bus.rd_dv, bus.host_rdv}), 32'b01);
    check("mix_hdata_m5", 32'(bus.host_rdata), 32'h2222);
    step(); #1;
    check("mix_dv_m6", 32'({bus.rd_dv, bus.host_rdv}), 32'b10);
    check("mix_data_m6", 32'(bus.rd_data), 32'h3333);
    step(); #1;
    check("mix_dv_m7", 32'({bus.rd_dv, bus.host_rdv}), 32'b00);

    // write path readback (0x41 written during turnaround test, 0x77 by host)
    step(); bus.rd_req = 1'b1; bus.rd_addr = 21'h00041; #1;
    step(); bus.host_req = 1'b1; bus.host_addr = 21'h00077; bus.rd_req = 1'b0; #1;
    step(); bus.host_req = 1'b0; #1;
    step(); #1;
    step(); #1;
    check("rb_wr_dv", 32'(bus.rd_dv), 32'd1);
    check("rb_wr_data", 32'(bus.rd_data), 32'hA5A5);
    step(); #1;
    check("rb_host_dv", 32'(bus.host_rdv), 32'd1);
    check("rb_host_data", 32'(bus.host_rdata), 32'hCAFE);

    // reset while a read is in flight: no dv afterwards
    step(); bus.rd_req = 1'b1; bus.rd_addr = 21'h00010; #1;
    check("mid_gnt", 32'(gnts), 32'b010);
    step(); bus.rd_req = 1'b0; resetb = 1'b0; #1;
    step(); resetb = 1'b1; #1;
    check("mid_oeb", 32'(bus.sram_oeb), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step(); #1;
      check("mid_no_dv", 32'({bus.rd_dv, bus.host_rdv}), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
